// File: rtl/sparrow_dbg_pkg.sv
// Shared debug-console types: line terminators, assembly FSM states and the
// committed-line record carried through the printf line FIFO.
package sparrow_dbg_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  // Record sized for the largest supported line; narrower lines use the low bits.
  localparam int MAX_LINE_LEN = 256;
  localparam int MAX_LEN_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_DISCARD = 2'd2
  } asm_state_t;

  typedef struct packed {
    logic [MAX_LEN_W-1:0]      len;
    logic                      cont;
    logic                      trunc;
    logic [MAX_LINE_LEN*8-1:0] data;
  } line_entry_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CHAR_LF) || (c == CHAR_CR);
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Power-of-two FIFO of completed lines; wrap bit on each pointer separates
// full from empty. Head is read combinationally.
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // When full, a simultaneous pop frees the slot the push overwrites.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/printf_line_buf.sv
// Assembles printf bytes into left-justified lines, wrapping or truncating
// overlong lines, and queues completed lines for a consumer.
module printf_line_buf
  import sparrow_dbg_pkg::*;
#(
  parameter int LINE_LEN = 64,
  parameter int DEPTH    = 4,
  parameter int WRAP_EN  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          char_valid,
  input  logic [7:0]                    char_data,
  input  logic                          flush,
  output logic                          line_valid,
  input  logic                          line_ready,
  output logic [LINE_LEN*8-1:0]         line_data,
  output logic [$clog2(LINE_LEN+1)-1:0] line_len,
  output logic                          line_cont,
  output logic                          line_trunc,
  output logic [15:0]                   drop_cnt,
  output logic                          busy
);

  localparam int CNT_W = $clog2(LINE_LEN+1);
  localparam int BUF_W = LINE_LEN*8;
  localparam int ENT_W = $bits(line_entry_t);

  asm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [15:0]      drop_q, drop_d;

  logic             commit, cm_cont, cm_trunc;
  logic [CNT_W-1:0] cm_len;
  logic [BUF_W-1:0] cm_data;
  logic             term;

  line_entry_t      push_ent, head_ent;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             unused_head;

  assign term = is_term(char_data);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    commit   = 1'b0;
    cm_cont  = 1'b0;
    cm_trunc = 1'b0;
    if (char_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!term) begin
            buf_d[BUF_W-8 +: 8] = char_data;
            cnt_d               = CNT_W'(1);
            state_d             = ST_FILL;
          end
        end
        ST_FILL: begin
          if (term) begin
            commit = 1'b1;
          end else begin
            buf_d[(LINE_LEN-1-int'(cnt_q))*8 +: 8] = char_data;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(LINE_LEN)) begin
              if (WRAP_EN != 0) begin
                commit  = 1'b1;
                cm_cont = 1'b1;
              end else begin
                state_d = ST_DISCARD;
              end
            end
          end
        end
        ST_DISCARD: begin
          if (term) begin
            commit   = 1'b1;
            cm_trunc = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Flush acts on whatever the byte left behind; an empty buffer ignores it.
    if (flush && !commit && (state_d != ST_IDLE)) begin
      commit   = 1'b1;
      cm_trunc = (state_d == ST_DISCARD);
    end
    cm_len  = cnt_d;
    cm_data = buf_d;
    if (commit) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      buf_d   = '0;
    end
  end

  always_comb begin
    push_ent                 = '0;
    push_ent.len[CNT_W-1:0]  = cm_len;
    push_ent.cont            = cm_cont;
    push_ent.trunc           = cm_trunc;
    push_ent.data[BUF_W-1:0] = cm_data;
  end

  assign fifo_pop  = !fifo_empty && line_ready;
  assign fifo_push = commit && (!fifo_full || fifo_pop);

  always_comb begin
    drop_d = drop_q;
    if (commit && fifo_full && !fifo_pop && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end

  line_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_data_i(push_ent),
    .pop_i      (fifo_pop),
    .head_o     (head_ent),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Head fields are gated so an empty FIFO presents all-zero outputs.
  assign line_valid = !fifo_empty;
  assign line_data  = fifo_empty ? '0   : head_ent.data[BUF_W-1:0];
  assign line_len   = fifo_empty ? '0   : head_ent.len[CNT_W-1:0];
  assign line_cont  = fifo_empty ? 1'b0 : head_ent.cont;
  assign line_trunc = fifo_empty ? 1'b0 : head_ent.trunc;
  assign drop_cnt   = drop_q;
  assign busy       = (state_q != ST_IDLE);

  assign unused_head = |(head_ent.data >> BUF_W) | |(head_ent.len >> CNT_W);

endmodule

// File: tb/tb_printf_line_buf.sv
// Directed bench: a wrapping and a truncating 8-character instance share one
// stimulus stream; each section resets and checks the relevant instance.
module tb_printf_line_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cv;
  logic [7:0] cd;
  logic       fl;
  logic       rdy;

  logic        w_valid, w_cont, w_trunc, w_busy;
  logic [63:0] w_data;
  logic [3:0]  w_len;
  logic [15:0] w_drop;
  logic        t_valid, t_cont, t_trunc, t_busy;
  logic [63:0] t_data;
  logic [3:0]  t_len;
  logic [15:0] t_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  printf_line_buf #(.LINE_LEN(8), .DEPTH(4), .WRAP_EN(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .char_valid(cv), .char_data(cd), .flush(fl),
    .line_valid(w_valid), .line_ready(rdy), .line_data(w_data), .line_len(w_len),
    .line_cont(w_cont), .line_trunc(w_trunc), .drop_cnt(w_drop), .busy(w_busy)
  );

  printf_line_buf #(.LINE_LEN(8), .DEPTH(4), .WRAP_EN(0)) u_trunc (
    .clk(clk), .rst_n(rst_n), .char_valid(cv), .char_data(cd), .flush(fl),
    .line_valid(t_valid), .line_ready(rdy), .line_data(t_data), .line_len(t_len),
    .line_cont(t_cont), .line_trunc(t_trunc), .drop_cnt(t_drop), .busy(t_busy)
  );

  typedef struct {
    logic        cv;
    logic [7:0]  cd;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [3:0]  elen;
    logic        ec;
    logic        eb;
    logic [63:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic f,
                               input logic r, input logic ev, input logic [3:0] el,
                               input logic ec, input logic eb, input logic [63:0] ed);
    vec_t x;
    x.cv = v; x.cd = d; x.fl = f; x.rdy = r;
    x.ev = ev; x.elen = el; x.ec = ec; x.eb = eb; x.ed = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    @(negedge clk);
    cv = v; cd = d; fl = f; rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cv = 1'b0; cd = 8'h00; fl = 1'b0; rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_clean(input string tag);
    chk({tag, " w_valid"}, 64'(w_valid), 64'd0);
    chk({tag, " w_busy"},  64'(w_busy),  64'd0);
    chk({tag, " w_data"},  w_data,       64'd0);
    chk({tag, " w_len"},   64'(w_len),   64'd0);
    chk({tag, " w_cont"},  64'(w_cont),  64'd0);
    chk({tag, " w_trunc"}, 64'(w_trunc), 64'd0);
    chk({tag, " w_drop"},  64'(w_drop),  64'd0);
    chk({tag, " t_valid"}, 64'(t_valid), 64'd0);
    chk({tag, " t_busy"},  64'(t_busy),  64'd0);
  endtask

  initial begin
    logic [7:0] pop_exp [3];
    rst_n = 1'b0; cv = 1'b0; cd = 8'h00; fl = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_clean("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // "Hi\n"
    vecs.push_back(mkv(1, 8'h48, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h69, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h0A, 0, 1, 1, 2, 0, 0, 64'h4869_0000_0000_0000));
    vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0, 0, 64'h0));
    // "ABCDEFGHIJ\r\n" wraps after H
    for (int i = 0; i < 7; i++)
      vecs.push_back(mkv(1, 8'(8'h41 + i), 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h48, 0, 1, 1, 8, 1, 0, 64'h4142_4344_4546_4748));
    vecs.push_back(mkv(1, 8'h49, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h4A, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h0D, 0, 1, 1, 2, 0, 0, 64'h494A_0000_0000_0000));
    vecs.push_back(mkv(1, 8'h0A, 0, 1, 0, 0, 0, 0, 64'h0));
    vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0, 0, 64'h0));
    // "abc" then flush; flush in IDLE; byte with flush
    vecs.push_back(mkv(1, 8'h61, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h62, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(1, 8'h63, 0, 1, 0, 0, 0, 1, 64'h0));
    vecs.push_back(mkv(0, 8'h00, 1, 1, 1, 3, 0, 0, 64'h6162_6300_0000_0000));
    vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0, 0, 64'h0));
    vecs.push_back(mkv(0, 8'h00, 1, 1, 0, 0, 0, 0, 64'h0));
    vecs.push_back(mkv(1, 8'h7A, 1, 1, 1, 1, 0, 0, 64'h7A00_0000_0000_0000));
    vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0, 0, 64'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      step(v.cv, v.cd, v.fl, v.rdy);
      chk($sformatf("vec%0d valid", i), 64'(w_valid), 64'(v.ev));
      chk($sformatf("vec%0d len", i),   64'(w_len),   64'(v.elen));
      chk($sformatf("vec%0d cont", i),  64'(w_cont),  64'(v.ec));
      chk($sformatf("vec%0d trunc", i), 64'(w_trunc), 64'd0);
      chk($sformatf("vec%0d busy", i),  64'(w_busy),  64'(v.eb));
      chk($sformatf("vec%0d data", i),  w_data,       v.ed);
    end

    // Truncation: 12 bytes then LF on the non-wrapping instance
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
      if (i == 7 || i == 11) begin
        chk($sformatf("trunc busy@%0d", i),  64'(t_busy),  64'd1);
        chk($sformatf("trunc valid@%0d", i), 64'(t_valid), 64'd0);
      end
    end
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    chk("trunc valid", 64'(t_valid), 64'd1);
    chk("trunc len",   64'(t_len),   64'd8);
    chk("trunc flag",  64'(t_trunc), 64'd1);
    chk("trunc cont",  64'(t_cont),  64'd0);
    chk("trunc busy",  64'(t_busy),  64'd0);
    chk("trunc data",  t_data,       64'h4142_4344_4546_4748);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("trunc hold data", t_data, 64'h4142_4344_4546_4748);
    chk("trunc drop",      64'(t_drop), 64'd0);

    // FIFO overflow with consumer stalled
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
      step(1'b1, 8'h0A, 1'b0, 1'b0);
    end
    chk("full drop",  64'(w_drop),  64'd2);
    chk("full valid", 64'(w_valid), 64'd1);
    chk("full head",  w_data,       64'h3000_0000_0000_0000);
    chk("full len",   64'(w_len),   64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stall hold", w_data, 64'h3000_0000_0000_0000);
    step(1'b1, 8'h36, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b1);
    chk("full+pop drop", 64'(w_drop), 64'd2);
    chk("full+pop head", w_data,      64'h3100_0000_0000_0000);
    pop_exp[0] = 8'h32; pop_exp[1] = 8'h33; pop_exp[2] = 8'h36;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk($sformatf("pop%0d valid", k), 64'(w_valid), 64'd1);
      chk($sformatf("pop%0d head", k),  w_data,       {pop_exp[k], 56'h0});
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drained valid", 64'(w_valid), 64'd0);

    // Reset mid-line discards the partial line and the drop count
    step(1'b1, 8'h78, 1'b0, 1'b1);
    step(1'b1, 8'h79, 1'b0, 1'b1);
    chk("xy busy", 64'(w_busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0; cv = 1'b0; fl = 1'b0;
    #1;
    chk_clean("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_clean("post rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/printf_line_buf.md
PRINTF_LINE_BUF -- requirements
Module: printf_line_buf

Interface
REQ-001 SHALL have parameter LINE_LEN, default 64, meaning maximum characters per line (range 8..256).
REQ-002 SHALL have parameter DEPTH, default 4, meaning completed lines held in the FIFO (power of two, 2..16).
REQ-003 SHALL have parameter WRAP_EN, default 1: 1 = split overlong lines, 0 = truncate overlong lines.
REQ-004 SHALL have the port clk, input, 1, the single clock; every flop updates on its rising edge.
REQ-005 SHALL have the port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-006 SHALL have the port char_valid, input, 1, strobe marking a printf byte; the byte is always accepted.
REQ-007 SHALL have the port char_data, input, 8, the printf byte, typically the CSR printf write data [7:0].
REQ-008 SHALL have the port flush, input, 1, request to commit the partial line.
REQ-009 SHALL have the port line_valid, output, 1, head of the FIFO is valid.
REQ-010 SHALL have the port line_ready, input, 1, consumer accepts the head line.
REQ-011 SHALL have the port line_data, output, LINE_LEN*8, the line string, left-justified.
REQ-012 SHALL have the port line_len, output, $clog2(LINE_LEN+1), the character count of the head line.
REQ-013 SHALL have the port line_cont, output, 1, head line was split by wrap and continues in the next entry.
REQ-014 SHALL have the port line_trunc, output, 1, head line lost characters to truncation.
REQ-015 SHALL have the port drop_cnt, output, 16, saturating count of lines dropped because the FIFO was full.
REQ-016 SHALL have the port busy, output, 1, assembly buffer holds at least one character.

Function
REQ-017 SHALL pack character i of a line into line_data[(LINE_LEN-1-i)*8 +: 8]; unused low bytes SHALL be zero.
REQ-018 SHALL use an assembly FSM with the states IDLE (count 0), FILL (0<count<LINE_LEN) and DISCARD (WRAP_EN=0 only, after the line is full).
REQ-019 SHALL treat 0x0A and 0x0D as terminators: in FILL, commit the line and return to IDLE; in IDLE, do nothing, so CRLF yields one line; terminators are never stored.
REQ-020 SHALL handle a non-terminator byte in IDLE/FILL by storing it at index count and incrementing count.
REQ-021 SHALL, when WRAP_EN=1 and the LINE_LEN-th character is stored, commit the line in that cycle with line_cont=1, then go to IDLE.
REQ-022 SHALL, when WRAP_EN=0 and the LINE_LEN-th character is stored, go to DISCARD; in DISCARD, non-terminators are dropped and a terminator commits the line with line_trunc=1.
REQ-023 SHALL, on flush with count>0 and no char_valid, commit the partial line; flush coincident with char_valid SHALL be processed after the byte in the same cycle; flush in IDLE SHALL be a no-op.
REQ-024 SHALL make a committed line visible on line_valid exactly one cycle after the commit cycle.
REQ-025 SHALL clear the assembly buffer to zero and count to 0 on every commit, whether the line was accepted or dropped.
REQ-026 SHALL pop the FIFO on line_valid && line_ready; line_data and the other head outputs SHALL hold stable while line_valid=1 and line_ready=0.
REQ-027 SHALL accept a commit when the FIFO is full only if a pop occurs in the same cycle; otherwise it SHALL drop the line and increment drop_cnt, saturating at 0xFFFF.
REQ-028 SHALL keep FIFO pointers wrapping modulo DEPTH with an extra wrap bit to tell full from empty.
REQ-029 SHALL drive busy=1 exactly when the FSM is not IDLE.

Reset
REQ-030 SHALL, while rst_n=0 asynchronously, force FSM=IDLE, count=0, assembly buffer=0, FIFO empty, line_valid=0, line_len=0, line_cont=0, line_trunc=0, line_data=0, drop_cnt=0, busy=0.
REQ-031 SHALL discard a partial line and all FIFO content on reset mid-operation; output starts clean after rst_n rises.

Structure
REQ-032 SHALL place the terminator constants (0x0A, 0x0D) and the FIFO entry struct {len, cont, trunc, data} in the shared package sparrow_dbg_pkg.
REQ-033 SHALL implement the FIFO as the sub-module line_fifo (parameters WIDTH and DEPTH, push/pop/full/empty); the FSM and packing SHALL live in printf_line_buf.

Verification
REQ-034 SHALL verify: bytes "Hi\n" -> one entry, line_len=2, line_data top bytes 0x48 0x69, rest zero, line_valid one cycle after the 0x0A.
REQ-035 SHALL verify: with LINE_LEN=8, WRAP_EN=1, 10 bytes "ABCDEFGHIJ" then "\r\n" -> entries "ABCDEFGH" (cont=1, len=8) and "IJ" (cont=0, len=2); the CR/LF pair yields nothing extra.
REQ-036 SHALL verify: with LINE_LEN=8, WRAP_EN=0, 12 bytes then 0x0A -> one entry, len=8, trunc=1, bytes 9..12 absent.
REQ-037 SHALL verify: with DEPTH=4, line_ready=0, 6 one-char lines -> 4 held, drop_cnt=2; then a commit with line_ready=1 while full -> accepted, drop_cnt stays 2.
REQ-038 SHALL verify: "abc", then flush -> len=3 entry; "xy", then rst_n low for 1 cycle -> no entry, all outputs at reset values.
